// File: rtl/vga_timing_pattern_if.sv
// rtl/vga_timing_pattern_if.sv - VGA pin and pixel-position bus
// Carries the registered VGA pins plus the aligned position/strobe outputs.
// Parameters: COLOR_W bits per colour channel, POS_W position width.
// master: driven by vga_timing_pattern; slave: consumer (pins, bench).
interface vga_timing_pattern_if #(
  parameter int COLOR_W = 4,
  parameter int POS_W   = 11
);
  logic               VGA_HS;
  logic               VGA_VS;
  logic [COLOR_W-1:0] VGA_R;
  logic [COLOR_W-1:0] VGA_G;
  logic [COLOR_W-1:0] VGA_B;
  logic               display_on;
  logic [POS_W-1:0]   hpos;
  logic [POS_W-1:0]   vpos;
  logic               frame_start;

  modport master (
    output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
    output display_on, hpos, vpos, frame_start
  );

  modport slave (
    input VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
    input display_on, hpos, vpos, frame_start
  );
endinterface

// File: rtl/vga_timing_pattern.sv
// rtl/vga_timing_pattern.sv - parametrised VGA timing generator with test patterns
// Ports:
//   clk        pixel clock
//   reset      synchronous active-high reset
//   mode       pattern select, latched once per frame
//   solid_rgb  {R,G,B} colour used by mode 0
//   vga        master side of vga_timing_pattern_if (syncs, RGB, display_on,
//              hpos/vpos of the current outputs, frame_start pulse)
// Optional feature macro: SCROLL_EN (patterns scroll left one pixel per frame).
// All outputs are registered one clock after the (hcnt,vcnt) they describe.
module vga_timing_pattern #(
  parameter int H_VIS     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VIS     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int COLOR_W   = 4,
  parameter int POS_W     = 11,
  parameter int CELL_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  vga_timing_pattern_if.master   vga
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_VIS_P  = POS_W'(H_VIS);
  localparam logic [POS_W-1:0] V_VIS_P  = POS_W'(V_VIS);
  localparam logic [POS_W-1:0] H_EDGE   = POS_W'(H_VIS - 1);
  localparam logic [POS_W-1:0] V_EDGE   = POS_W'(V_VIS - 1);
  localparam logic [POS_W-1:0] HS_BEG   = POS_W'(H_VIS + H_FP);
  localparam logic [POS_W-1:0] HS_END   = POS_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] VS_BEG   = POS_W'(V_VIS + V_FP);
  localparam logic [POS_W-1:0] VS_END   = POS_W'(V_VIS + V_FP + V_SYNC);

  logic [POS_W-1:0]   hcnt;
  logic [POS_W-1:0]   vcnt;
  logic [POS_W-1:0]   px;
  logic [POS_W-1:0]   py;
  logic [2:0]         mode_q;
  logic               h_last;
  logic               v_last;
  logic               active;
  logic               hs_act;
  logic               vs_act;
  logic [COLOR_W-1:0] pat_r;
  logic [COLOR_W-1:0] pat_g;
  logic [COLOR_W-1:0] pat_b;
  logic               unused_px;

`ifdef SCROLL_EN
  logic [7:0] frame_cnt;
  assign px = hcnt + POS_W'(frame_cnt);
`else
  assign px = hcnt;
`endif
  assign py = vcnt;

  // Only a few low bits of the pattern x coordinate select a pattern.
  assign unused_px = ^px;

  assign h_last = (hcnt == H_LAST);
  assign v_last = (vcnt == V_LAST);
  assign active = (hcnt < H_VIS_P) && (vcnt < V_VIS_P);
  assign hs_act = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_act = (vcnt >= VS_BEG) && (vcnt < VS_END);

  always_comb begin
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    if (active) begin
      case (mode_q)
        3'd0: {pat_r, pat_g, pat_b} = solid_rgb;
        3'd1: begin
          pat_r = {COLOR_W{px[CELL_LOG2]}};
          pat_g = {COLOR_W{px[CELL_LOG2+1]}};
          pat_b = {COLOR_W{px[CELL_LOG2+2]}};
        end
        3'd2: begin
          if (px[CELL_LOG2] ^ py[CELL_LOG2]) begin
            pat_r = '1;
            pat_g = '1;
            pat_b = '1;
          end
        end
        3'd3: begin
          // The right/bottom border uses the raw counters so the frame edge
          // stays put even when the pattern scrolls.
          if ((px[CELL_LOG2-1:0] == '0) || (py[CELL_LOG2-1:0] == '0) ||
              (hcnt == H_EDGE) || (vcnt == V_EDGE)) begin
            pat_r = '1;
            pat_g = '1;
            pat_b = '1;
          end
        end
        3'd4: begin
          pat_r = px[COLOR_W+1:2];
          pat_g = py[COLOR_W+1:2];
        end
        3'd5: begin
          if (px[CELL_LOG2]) pat_g = '1;
          else               pat_b = '1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt            <= '0;
      vcnt            <= '0;
      mode_q          <= mode;
      vga.VGA_HS      <= ~SYNC_POL;
      vga.VGA_VS      <= ~SYNC_POL;
      vga.VGA_R       <= '0;
      vga.VGA_G       <= '0;
      vga.VGA_B       <= '0;
      vga.display_on  <= 1'b0;
      vga.hpos        <= '0;
      vga.vpos        <= '0;
      vga.frame_start <= 1'b0;
`ifdef SCROLL_EN
      frame_cnt       <= 8'd0;
`endif
    end else begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + POS_W'(1);
      end else begin
        hcnt <= hcnt + POS_W'(1);
      end

      // Frame-level state changes on the edge that emits the last pixel, so
      // every pixel of a frame sees one mode and one scroll offset, and the
      // new values are in place for the next frame_start.
      if (h_last && v_last) begin
        mode_q    <= mode;
`ifdef SCROLL_EN
        frame_cnt <= frame_cnt + 8'd1;
`endif
      end

      vga.VGA_HS      <= hs_act ? SYNC_POL : ~SYNC_POL;
      vga.VGA_VS      <= vs_act ? SYNC_POL : ~SYNC_POL;
      vga.VGA_R       <= pat_r;
      vga.VGA_G       <= pat_g;
      vga.VGA_B       <= pat_b;
      vga.display_on  <= active;
      vga.hpos        <= hcnt;
      vga.vpos        <= vcnt;
      vga.frame_start <= (hcnt == '0) && (vcnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern.sv
// tb/tb_vga_timing_pattern.sv - self-checking bench for vga_timing_pattern (reduced timing)
module tb_vga_timing_pattern;

  // Reduced timing: 80 clk per line, 22 lines, 1760 clk per frame, 8-pixel cells.
  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 16, VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
`ifdef SCROLL_EN
  localparam int SCROLL = 1;
`else
  localparam int SCROLL = 0;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  mode;
  logic [11:0] solid_rgb;
  int          t;
  int          checks;
  int          passed;

  vga_timing_pattern_if #(.COLOR_W(4), .POS_W(11)) vga_bus ();

  vga_timing_pattern #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .COLOR_W(4), .POS_W(11), .CELL_LOG2(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .solid_rgb(solid_rgb),
    .vga(vga_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] exp_rgb(input int m, input int h, input int v,
                                          input int f, input logic [11:0] sol);
    logic [10:0] px;
    logic [10:0] py;
    logic [11:0] r;
    px = 11'((h + SCROLL * (f % 256)) % 2048);
    py = 11'(v);
    r  = 12'h000;
    if (h < HV && v < VV) begin
      case (m)
        0: r = sol;
        1: r = {{4{px[3]}}, {4{px[4]}}, {4{px[5]}}};
        2: r = (px[3] ^ py[3]) ? 12'hFFF : 12'h000;
        3: r = (px[2:0] == 3'd0 || py[2:0] == 3'd0 || h == HV - 1 || v == VV - 1) ? 12'hFFF : 12'h000;
        4: r = {px[5:2], py[5:2], 4'h0};
        5: r = px[3] ? 12'h0F0 : 12'h00F;
        default: r = 12'h000;
      endcase
    end
    return r;
  endfunction

  function automatic logic [11:0] rgb_now();
    return {vga_bus.VGA_R, vga_bus.VGA_G, vga_bus.VGA_B};
  endfunction

  task automatic tick();
    @(negedge clk);
    t++;
  endtask

  // Checks one full frame of RGB against the model; switches the mode input
  // at pixel (0, sw_line) so the next frame uses m_next.
  task automatic check_frame(input int m_exp, input int m_next, input logic [11:0] sol_next,
                             input int sw_line, input int ph, input int pv,
                             output logic [11:0] probe, output int bad);
    int p, h, v, f;
    bad   = 0;
    probe = 12'hxxx;
    do begin
      tick();
      p = t - 1;
      h = p % HT;
      v = (p / HT) % VT;
      f = p / FT;
      if (rgb_now() !== exp_rgb(m_exp, h, v, f, solid_rgb)) bad++;
      if (h == ph && v == pv) probe = rgb_now();
      if (h == 0 && v == sw_line) begin
        mode      = 3'(m_next);
        solid_rgb = sol_next;
      end
    end while (((t - 1) % FT) != FT - 1);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    mode      = 3'd5;
    solid_rgb = 12'h000;
    repeat (3) @(negedge clk);
    checks++; if (vga_bus.VGA_HS !== 1'b1) $display("FAIL reset_hs: got %b want 1", vga_bus.VGA_HS); else passed++;
    checks++; if (vga_bus.VGA_VS !== 1'b1) $display("FAIL reset_vs: got %b want 1", vga_bus.VGA_VS); else passed++;
    checks++; if (rgb_now() !== 12'h000) $display("FAIL reset_rgb: got %h want 000", rgb_now()); else passed++;
    checks++; if (vga_bus.display_on !== 1'b0) $display("FAIL reset_de: got %b want 0", vga_bus.display_on); else passed++;
    checks++; if (vga_bus.hpos !== 11'd0) $display("FAIL reset_hpos: got %0d want 0", vga_bus.hpos); else passed++;
    checks++; if (vga_bus.vpos !== 11'd0) $display("FAIL reset_vpos: got %0d want 0", vga_bus.vpos); else passed++;
    checks++; if (vga_bus.frame_start !== 1'b0) $display("FAIL reset_fs: got %b want 0", vga_bus.frame_start); else passed++;
    reset = 1'b0;
    t     = 0;
  endtask

  // Two frames of mode 5 (loaded during reset): sync timing, positions and legacy colours.
  task automatic test_timing();
    int p, h, v, f;
    int pos_bad, de_bad, rgb_bad;
    int hs_first, hs_rise, hs_second, vs_first, vs_rise, vs_line;
    int fs_n, fs_t0, fs_t1;
    logic hs_prev, vs_prev;
    pos_bad = 0; de_bad = 0; rgb_bad = 0;
    hs_first = -1; hs_rise = -1; hs_second = -1;
    vs_first = -1; vs_rise = -1; vs_line = -1;
    fs_n = 0; fs_t0 = -1; fs_t1 = -1;
    hs_prev = 1'b1; vs_prev = 1'b1;
    for (int i = 0; i < 2 * FT; i++) begin
      tick();
      p = t - 1;
      h = p % HT;
      v = (p / HT) % VT;
      f = p / FT;
      if (t == FT + 1) mode = 3'd2;
      if (int'(vga_bus.hpos) != h || int'(vga_bus.vpos) != v) pos_bad++;
      if (vga_bus.display_on !== (h < HV && v < VV)) de_bad++;
      if (rgb_now() !== exp_rgb(5, h, v, f, solid_rgb)) rgb_bad++;
      if (p == 0) begin
        checks++; if (rgb_now() !== 12'h00F) $display("FAIL legacy_h0: got %h want 00F", rgb_now()); else passed++;
      end
      if (p == 8) begin
        checks++; if (rgb_now() !== 12'h0F0) $display("FAIL legacy_h8: got %h want 0F0", rgb_now()); else passed++;
      end
      if (p == 70) begin
        checks++; if (rgb_now() !== 12'h000) $display("FAIL legacy_blank: got %h want 000", rgb_now()); else passed++;
      end
      if (hs_prev && !vga_bus.VGA_HS) begin
        if (hs_first < 0) hs_first = t;
        else if (hs_second < 0) hs_second = t;
      end
      if (!hs_prev && vga_bus.VGA_HS && hs_rise < 0) hs_rise = t;
      if (vs_prev && !vga_bus.VGA_VS && vs_first < 0) begin
        vs_first = t;
        vs_line  = int'(vga_bus.vpos);
      end
      if (!vs_prev && vga_bus.VGA_VS && vs_rise < 0) vs_rise = t;
      if (vga_bus.frame_start === 1'b1) begin
        fs_n++;
        if (fs_t0 < 0) fs_t0 = t;
        else if (fs_t1 < 0) fs_t1 = t;
      end
      hs_prev = vga_bus.VGA_HS;
      vs_prev = vga_bus.VGA_VS;
    end
    checks++; if (hs_first != 69) $display("FAIL hs_first: got %0d want 69", hs_first); else passed++;
    checks++; if (hs_rise - hs_first != 8) $display("FAIL hs_width: got %0d want 8", hs_rise - hs_first); else passed++;
    checks++; if (hs_second - hs_first != 80) $display("FAIL hs_period: got %0d want 80", hs_second - hs_first); else passed++;
    checks++; if (vs_first != 1441) $display("FAIL vs_first: got %0d want 1441", vs_first); else passed++;
    checks++; if (vs_line != 18) $display("FAIL vs_line: got %0d want 18", vs_line); else passed++;
    checks++; if (vs_rise - vs_first != 160) $display("FAIL vs_width: got %0d want 160", vs_rise - vs_first); else passed++;
    checks++; if (fs_n != 2) $display("FAIL fs_count: got %0d want 2", fs_n); else passed++;
    checks++; if (fs_t0 != 1) $display("FAIL fs_first: got %0d want 1", fs_t0); else passed++;
    checks++; if (fs_t1 - fs_t0 != 1760) $display("FAIL fs_period: got %0d want 1760", fs_t1 - fs_t0); else passed++;
    checks++; if (pos_bad != 0) $display("FAIL hvpos: got %0d bad cycles want 0", pos_bad); else passed++;
    checks++; if (de_bad != 0) $display("FAIL display_on: got %0d bad cycles want 0", de_bad); else passed++;
    checks++; if (rgb_bad != 0) $display("FAIL legacy_frames: got %0d bad pixels want 0", rgb_bad); else passed++;
  endtask

  // Checker frame with a switch to solid mid-frame, then the solid frame.
  task automatic test_mode_switch();
    logic [11:0] pr;
    int bad;
    check_frame(2, 0, 12'h5A3, 8, 0, 9, pr, bad);
    checks++; if (bad != 0) $display("FAIL checker_frame: got %0d bad pixels want 0", bad); else passed++;
    checks++; if (pr !== 12'hFFF) $display("FAIL checker_probe: got %h want FFF", pr); else passed++;
    check_frame(0, 3, 12'h5A3, 0, 0, 0, pr, bad);
    checks++; if (bad != 0) $display("FAIL solid_frame: got %0d bad pixels want 0", bad); else passed++;
    checks++; if (pr !== 12'h5A3) $display("FAIL solid_probe: got %h want 5A3", pr); else passed++;
  endtask

  task automatic test_patterns();
    logic [11:0] pr;
    int bad;
    check_frame(3, 4, 12'h5A3, 0, 63, 5, pr, bad);
    checks++; if (bad != 0) $display("FAIL grid_frame: got %0d bad pixels want 0", bad); else passed++;
    checks++; if (pr !== 12'hFFF) $display("FAIL grid_edge: got %h want FFF", pr); else passed++;
    check_frame(4, 6, 12'h5A3, 0, 20, 12, pr, bad);
    checks++; if (bad != 0) $display("FAIL gradient_frame: got %0d bad pixels want 0", bad); else passed++;
    checks++; if (pr !== ((SCROLL != 0) ? 12'h630 : 12'h530)) $display("FAIL gradient_probe: got %h want %h", pr, (SCROLL != 0) ? 12'h630 : 12'h530); else passed++;
    check_frame(6, 1, 12'h5A3, 0, 10, 10, pr, bad);
    checks++; if (bad != 0) $display("FAIL black_frame: got %0d bad pixels want 0", bad); else passed++;
  endtask

  // One-cycle reset in the middle of a line, then two bar frames from (0,0).
  task automatic test_mid_reset();
    logic [11:0] pr;
    int bad, n;
    n = 0;
    while (int'(vga_bus.hpos) != 29 && n < 200) begin
      tick();
      n++;
    end
    checks++; if (vga_bus.hpos !== 11'd29) $display("FAIL midreset_wait: got %0d want 29", vga_bus.hpos); else passed++;
    reset = 1'b1;
    tick();
    checks++; if (vga_bus.hpos !== 11'd0 || vga_bus.vpos !== 11'd0) $display("FAIL midreset_pos: got %0d,%0d want 0,0", vga_bus.hpos, vga_bus.vpos); else passed++;
    checks++; if ({vga_bus.VGA_HS, vga_bus.VGA_VS} !== 2'b11) $display("FAIL midreset_sync: got %b want 11", {vga_bus.VGA_HS, vga_bus.VGA_VS}); else passed++;
    checks++; if (rgb_now() !== 12'h000 || vga_bus.display_on !== 1'b0 || vga_bus.frame_start !== 1'b0) $display("FAIL midreset_out: got rgb %h de %b fs %b want 000 0 0", rgb_now(), vga_bus.display_on, vga_bus.frame_start); else passed++;
    reset = 1'b0;
    t     = 0;
    tick();
    checks++; if (vga_bus.frame_start !== 1'b1 || vga_bus.hpos !== 11'd0 || vga_bus.vpos !== 11'd0) $display("FAIL restart: got fs %b pos %0d,%0d want 1 0,0", vga_bus.frame_start, vga_bus.hpos, vga_bus.vpos); else passed++;
    tick();
    checks++; if (vga_bus.hpos !== 11'd1) $display("FAIL restart_next: got %0d want 1", vga_bus.hpos); else passed++;
    check_frame(1, 1, 12'h5A3, 0, 7, 0, pr, bad);
    checks++; if (bad != 0) $display("FAIL bars_frame0: got %0d bad pixels want 0", bad); else passed++;
    checks++; if (pr !== 12'h000) $display("FAIL bars_f0_h7: got %h want 000", pr); else passed++;
    check_frame(1, 1, 12'h5A3, 0, 7, 0, pr, bad);
    checks++; if (bad != 0) $display("FAIL bars_frame1: got %0d bad pixels want 0", bad); else passed++;
    checks++; if (pr !== ((SCROLL != 0) ? 12'hF00 : 12'h000)) $display("FAIL bars_f1_h7: got %h want %h", pr, (SCROLL != 0) ? 12'hF00 : 12'h000); else passed++;
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    t         = 0;
    reset     = 1'b1;
    mode      = 3'd5;
    solid_rgb = 12'h000;
    test_reset();
    test_timing();
    test_mode_switch();
    test_patterns();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
